// File: rtl/dnn_cfg_pkg.sv
// Shared definitions for the per-layer configuration stream writers (bias, weights).
package dnn_cfg_pkg;

  localparam int unsigned CFG_WORD_W = 32;
  localparam int unsigned OP_W       = 8;
  localparam int unsigned LAYER_W    = 8;
  localparam int unsigned NEURON_W   = 16;

  // Header word field positions
  localparam int unsigned HDR_OP_MSB     = 31;
  localparam int unsigned HDR_OP_LSB     = 24;
  localparam int unsigned HDR_LAYER_MSB  = 23;
  localparam int unsigned HDR_LAYER_LSB  = 16;
  localparam int unsigned HDR_NEURON_MSB = 15;
  localparam int unsigned HDR_NEURON_LSB = 0;

  localparam logic [OP_W-1:0]     OP_BIAS_WR   = 8'hB1;
  localparam logic [OP_W-1:0]     OP_BIAS_CLR  = 8'hB0;
  localparam logic [NEURON_W-1:0] NEURON_BCAST = 16'hFFFF;

  // Packet parser states
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_SKIP = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/cfg_hdr_decode.sv
// Combinational header decoder: opcode classification and layer/neuron match.
module cfg_hdr_decode
  import dnn_cfg_pkg::*;
#(
  parameter int unsigned LAYER_NO  = 1,
  parameter int unsigned NEURON_NO = 5
) (
  input  logic [CFG_WORD_W-1:0] i_hdr,
  output logic                  o_is_wr_c,
  output logic                  o_is_clr_c,
  output logic                  o_match_c,
  output logic                  o_bad_op_c
);

  logic [OP_W-1:0]     w_op;
  logic [LAYER_W-1:0]  w_layer;
  logic [NEURON_W-1:0] w_neuron;

  assign w_op     = i_hdr[HDR_OP_MSB:HDR_OP_LSB];
  assign w_layer  = i_hdr[HDR_LAYER_MSB:HDR_LAYER_LSB];
  assign w_neuron = i_hdr[HDR_NEURON_MSB:HDR_NEURON_LSB];

  // Opcode classification and address match, broadcast neuron included
  always_comb begin
    o_is_wr_c  = (w_op == OP_BIAS_WR);
    o_is_clr_c = (w_op == OP_BIAS_CLR);
    o_bad_op_c = !(o_is_wr_c || o_is_clr_c);
    o_match_c  = (w_layer == LAYER_W'(LAYER_NO)) &&
                 ((w_neuron == NEURON_W'(NEURON_NO)) || (w_neuron == NEURON_BCAST));
  end

endmodule

// File: rtl/bias_cfg_writer.sv
// Captures one neuron's bias from the shared header+value configuration stream.
module bias_cfg_writer
  import dnn_cfg_pkg::*;
#(
  parameter int unsigned neuronNo   = 5,
  parameter int unsigned layerNo    = 1,
  parameter int unsigned dataWidth  = 32,
  parameter logic [31:0] resetValue = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_last,
  output logic                 cfg_ready,
  output logic [dataWidth-1:0] b,
  output logic                 b_valid,
  output logic                 cfg_err,
  output logic                 busy
);

  cfg_state_e           r_state;
  logic                 r_ready;
  logic [dataWidth-1:0] r_b;
  logic                 r_b_valid;
  logic                 r_err;
  logic                 r_busy;

  logic w_xfer;
  logic w_is_wr;
  logic w_is_clr;
  logic w_match;
  logic w_bad_op;

  assign w_xfer = cfg_valid && r_ready;

  cfg_hdr_decode #(
    .LAYER_NO  (layerNo),
    .NEURON_NO (neuronNo)
  ) u_hdr_decode (
    .i_hdr      (cfg_data),
    .o_is_wr_c  (w_is_wr),
    .o_is_clr_c (w_is_clr),
    .o_match_c  (w_match),
    .o_bad_op_c (w_bad_op)
  );

  // Packet parser; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HDR;
      r_ready   <= 1'b0;
      r_b       <= dataWidth'(resetValue);
      r_b_valid <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_HDR: begin
            if (w_is_wr) begin
              // A write header flagged last has no value word to follow
              if (cfg_last) begin
                r_err <= 1'b1;
              end else begin
                r_state <= w_match ? S_DATA : S_SKIP;
                r_busy  <= 1'b1;
              end
            end else if (w_is_clr) begin
              if (w_match) begin
                r_b       <= dataWidth'(resetValue);
                r_b_valid <= 1'b0;
              end
            end else if (w_bad_op) begin
              r_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_b       <= cfg_data[dataWidth-1:0];
            r_b_valid <= 1'b1;
            r_err     <= !cfg_last;
            r_state   <= S_HDR;
            r_busy    <= 1'b0;
          end
          S_SKIP: begin
            r_err   <= !cfg_last;
            r_state <= S_HDR;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_HDR;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready = r_ready;
  assign b         = r_b;
  assign b_valid   = r_b_valid;
  assign cfg_err   = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bias_cfg_writer.sv
// Directed-stimulus bench for bias_cfg_writer with a packet-level reference model.
module tb_bias_cfg_writer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        cfg_ready;
  logic [31:0] b;
  logic        b_valid;
  logic        cfg_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bias_cfg_writer #(
    .neuronNo   (5),
    .layerNo    (1),
    .dataWidth  (32),
    .resetValue (32'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .b         (b),
    .b_valid   (b_valid),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is "open" after a write header until its value word arrives.
  logic        m_started = 1'b0;
  logic        m_rdy, m_open, m_mine, m_bv, m_err;
  logic [31:0] m_b;

  always @(posedge clk) begin
    logic       hit;
    logic [7:0] op;
    if (rst) begin
      m_rdy = 1'b0; m_open = 1'b0; m_mine = 1'b0;
      m_b = 32'd0; m_bv = 1'b0; m_err = 1'b0;
      m_started = 1'b1;
    end else if (m_started) begin
      m_err = 1'b0;
      if (cfg_valid && m_rdy) begin
        if (m_open) begin
          if (m_mine) begin
            m_b  = cfg_data;
            m_bv = 1'b1;
          end
          m_err  = !cfg_last;
          m_open = 1'b0;
        end else begin
          op  = cfg_data[31:24];
          hit = (cfg_data[23:16] == 8'd1) &&
                ((cfg_data[15:0] == 16'd5) || (cfg_data[15:0] == 16'hFFFF));
          if (op == 8'hB1) begin
            if (cfg_last) m_err = 1'b1;
            else begin
              m_open = 1'b1;
              m_mine = hit;
            end
          end else if (op == 8'hB0) begin
            if (hit) begin
              m_b  = 32'd0;
              m_bv = 1'b0;
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
      m_rdy = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("m_ready",   32'(cfg_ready), 32'(m_rdy));
      chk("m_b",       b,              m_b);
      chk("m_b_valid", 32'(b_valid),   32'(m_bv));
      chk("m_cfg_err", 32'(cfg_err),   32'(m_err));
      chk("m_busy",    32'(busy),      32'(m_open));
    end
  end

  // One word on the stream, then the bus goes idle; returns at the negedge after the handshake
  task automatic send(input logic [31:0] d, input logic last);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = 32'd0;
    cfg_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 32'd0; cfg_last = 1'b0;

    // 1: reset and idle
    @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_bv", 32'(b_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);
    idle(2);

    // 2: matching write
    send(32'hB101_0005, 1'b0);
    chk("t2_busy", 32'(busy), 32'd1);
    send(32'h0000_1234, 1'b1);
    chk("t2_b", b, 32'h1234);
    chk("t2_bv", 32'(b_valid), 32'd1);
    chk("t2_err", 32'(cfg_err), 32'd0);

    // 3: other neuron skipped, broadcast accepted
    send(32'hB101_0006, 1'b0);
    chk("t3_busy_skip", 32'(busy), 32'd1);
    idle(2);
    send(32'hDEAD_BEEF, 1'b1);
    chk("t3_b_unchanged", b, 32'h1234);
    send(32'hB101_FFFF, 1'b0);
    send(32'h0000_0042, 1'b1);
    chk("t3_b_bcast", b, 32'h42);

    // 4: bad opcode, then recovery
    send(32'hC101_0005, 1'b0);
    chk("t4_err_pulse", 32'(cfg_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_err_drop", 32'(cfg_err), 32'd0);
    send(32'hB101_0005, 1'b0);
    send(32'h0000_0007, 1'b1);
    chk("t4_b", b, 32'h7);

    // truncated write header and non-matching clear
    send(32'hB101_0005, 1'b1);
    chk("trunc_err", 32'(cfg_err), 32'd1);
    chk("trunc_busy", 32'(busy), 32'd0);
    send(32'hB002_0005, 1'b1);
    chk("clr_other_layer", b, 32'h7);

    // 5: reset mid-packet abandons it
    send(32'hB101_0005, 1'b0);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_b", b, 32'd0);
    chk("t5_bv", 32'(b_valid), 32'd0);
    chk("t5_ready", 32'(cfg_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    send(32'h0000_0099, 1'b1);
    chk("t5_err", 32'(cfg_err), 32'd1);
    chk("t5_b_after", b, 32'd0);

    // 6: clear, then over-long packet
    send(32'hB101_0005, 1'b0);
    send(32'h0000_1234, 1'b1);
    chk("t6_load", b, 32'h1234);
    send(32'hB001_0005, 1'b1);
    chk("t6_clr_b", b, 32'd0);
    chk("t6_clr_bv", 32'(b_valid), 32'd0);
    send(32'hB101_0005, 1'b0);
    send(32'h0000_0055, 1'b0);
    chk("t6_b", b, 32'h55);
    chk("t6_err", 32'(cfg_err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
